// File: rtl/branch_predictor.sv
// Bimodal BHT + direct-mapped BTB next-PC predictor with registered mispredict/redirect.
// Optional BPRED_STATS_EN adds stat_updates / stat_mispredicts counters.
module branch_predictor #(
  parameter int WIDTH    = 32,
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] f_pc,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  input  logic             upd_valid,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic             upd_uncond,
  input  logic             upd_taken,
  input  logic [WIDTH-1:0] upd_target,
  input  logic [WIDTH-1:0] upd_pred_target,
  output logic             mispredict,
  output logic [WIDTH-1:0] redirect_pc
`ifdef BPRED_STATS_EN
  ,
  output logic [31:0]      stat_updates,
  output logic [31:0]      stat_mispredicts
`endif
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;

  logic [1:0]          bht        [ENTRIES];
  logic [ENTRIES-1:0]  btb_valid;
  logic [TAG_BITS-1:0] btb_tag    [ENTRIES];
  logic [WIDTH-1:0]    btb_target [ENTRIES];

  logic [IDX_BITS-1:0] f_idx, u_idx;
  logic [TAG_BITS-1:0] f_tag, u_tag;
  logic                hit;
  logic                eff_taken;
  logic [1:0]          cnt_nxt;
  logic [WIDTH-1:0]    correct_pc;
  logic                mp_nxt;

  assign f_idx = f_pc[IDX_BITS+1:2];
  assign f_tag = f_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign u_idx = upd_pc[IDX_BITS+1:2];
  assign u_tag = upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

  // Lookup reads the registered tables only, so a same-cycle update is not bypassed.
  always_comb begin
    hit         = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
    pred_taken  = hit && bht[f_idx][1];
    pred_target = pred_taken ? btb_target[f_idx] : f_pc + WIDTH'(4);
  end

  always_comb begin
    eff_taken  = upd_uncond | upd_taken;
    correct_pc = eff_taken ? upd_target : upd_pc + WIDTH'(4);
    mp_nxt     = upd_valid && (correct_pc != upd_pred_target);
    cnt_nxt    = bht[u_idx];
    if (upd_uncond) begin
      cnt_nxt = 2'b11;
    end else if (eff_taken) begin
      if (bht[u_idx] != 2'b11) cnt_nxt = bht[u_idx] + 2'b01;
    end else begin
      if (bht[u_idx] != 2'b00) cnt_nxt = bht[u_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) bht[i[IDX_BITS-1:0]] <= 2'b01;
      btb_valid <= '0;
    end else if (upd_valid) begin
      bht[u_idx] <= cnt_nxt;
      if (eff_taken) btb_valid[u_idx] <= 1'b1;
    end
  end

  // Tag/target storage is qualified by btb_valid and needs no reset.
  always_ff @(posedge clk) begin
    if (upd_valid && eff_taken) begin
      btb_tag[u_idx]    <= u_tag;
      btb_target[u_idx] <= upd_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      mispredict <= mp_nxt;
      if (upd_valid) redirect_pc <= correct_pc;
    end
  end

`ifdef BPRED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (upd_valid) stat_updates <= stat_updates + 32'd1;
      if (mp_nxt)    stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default parameters).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] f_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_uncond;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BPRED_STATS_EN
  logic [31:0] stat_updates;
  logic [31:0] stat_mispredicts;
`endif

  int vectors    = 0;
  int miscompares = 0;

  branch_predictor #(.WIDTH(32), .IDX_BITS(6), .TAG_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .f_pc(f_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_uncond(upd_uncond),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BPRED_STATS_EN
    , .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  // Present one update at the falling edge, let it take effect on the rising edge.
  task automatic do_upd(input logic [31:0] pc, input logic unc, input logic tk,
                        input logic [31:0] tgt, input logic [31:0] ptgt);
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = pc; upd_uncond = unc; upd_taken = tk;
    upd_target = tgt; upd_pred_target = ptgt;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; f_pc = 32'h100; upd_valid = 1'b0; upd_pc = '0;
    upd_uncond = 1'b0; upd_taken = 1'b0; upd_target = '0; upd_pred_target = '0;
    #1;
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      miscompares++;
      $display("FAIL reset_lookup: got taken=%b target=%h, want 0/00000104", pred_taken, pred_target);
    end
    vectors++;
    if (mispredict !== 1'b0 || redirect_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_regs: got mp=%b redirect=%h, want 0/00000000", mispredict, redirect_pc);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      f_pc = 32'h1000 + 32'(i) * 4;
      #1;
      vectors++;
      if (pred_taken !== 1'b0 || pred_target !== f_pc + 32'd4) begin
        miscompares++;
        $display("FAIL reset_sweep[%0d]: got taken=%b target=%h, want 0/%h", i, pred_taken, pred_target, f_pc + 32'd4);
      end
    end
  endtask

  task automatic test_cold_taken;
    do_upd(32'h100, 1'b0, 1'b1, 32'h80, 32'h104);
    vectors++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h80) begin
      miscompares++;
      $display("FAIL cold_mp: got mp=%b redirect=%h, want 1/00000080", mispredict, redirect_pc);
    end
    f_pc = 32'h100; #1;
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      miscompares++;
      $display("FAIL cold_lookup: got taken=%b target=%h, want 1/00000080", pred_taken, pred_target);
    end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 4; i++) do_upd(32'h100, 1'b0, 1'b1, 32'h80, 32'h80);
    vectors++;
    if (mispredict !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_taken_mp: got %b, want 0", mispredict);
    end
    do_upd(32'h100, 1'b0, 1'b0, 32'h80, 32'h80);        // 11 -> 10
    vectors++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h104) begin
      miscompares++;
      $display("FAIL sat_nt1_mp: got mp=%b redirect=%h, want 1/00000104", mispredict, redirect_pc);
    end
    f_pc = 32'h100; #1;
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      miscompares++;
      $display("FAIL sat_after_nt1: got taken=%b target=%h, want 1/00000080", pred_taken, pred_target);
    end
    do_upd(32'h100, 1'b0, 1'b0, 32'h80, 32'h80);        // 10 -> 01
    f_pc = 32'h100; #1;
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      miscompares++;
      $display("FAIL sat_after_nt2: got taken=%b target=%h, want 0/00000104", pred_taken, pred_target);
    end
    for (int i = 0; i < 3; i++) do_upd(32'h100, 1'b0, 1'b0, 32'h80, 32'h104);
    vectors++;
    if (mispredict !== 1'b0 || redirect_pc !== 32'h104) begin
      miscompares++;
      $display("FAIL sat_nt_correct: got mp=%b redirect=%h, want 0/00000104", mispredict, redirect_pc);
    end
    do_upd(32'h100, 1'b0, 1'b1, 32'h80, 32'h104);       // 00 -> 01 if floor held
    f_pc = 32'h100; #1;
    vectors++;
    if (pred_taken !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_floor: got taken=%b, want 0", pred_taken);
    end
    do_upd(32'h100, 1'b0, 1'b1, 32'h80, 32'h104);       // 01 -> 10
    f_pc = 32'h100; #1;
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      miscompares++;
      $display("FAIL sat_recover: got taken=%b target=%h, want 1/00000080", pred_taken, pred_target);
    end
  endtask

  task automatic test_correct;
    do_upd(32'h100, 1'b0, 1'b1, 32'h80, 32'h80);
    vectors++;
    if (mispredict !== 1'b0 || redirect_pc !== 32'h80) begin
      miscompares++;
      $display("FAIL correct_pred: got mp=%b redirect=%h, want 0/00000080", mispredict, redirect_pc);
    end
    do_upd(32'h100, 1'b0, 1'b1, 32'h80, 32'h84);        // right direction, wrong target
    vectors++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h80) begin
      miscompares++;
      $display("FAIL wrong_target: got mp=%b redirect=%h, want 1/00000080", mispredict, redirect_pc);
    end
    @(posedge clk); #1;
    vectors++;
    if (mispredict !== 1'b0 || redirect_pc !== 32'h80) begin
      miscompares++;
      $display("FAIL idle_hold: got mp=%b redirect=%h, want 0/00000080", mispredict, redirect_pc);
    end
  endtask

  task automatic test_alias;
    f_pc = 32'h200; #1;
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h204) begin
      miscompares++;
      $display("FAIL alias_tag: got taken=%b target=%h, want 0/00000204", pred_taken, pred_target);
    end
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = 32'h200; upd_uncond = 1'b0; upd_taken = 1'b1;
    upd_target = 32'h300; upd_pred_target = 32'h204; f_pc = 32'h200;
    #1;
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h204) begin
      miscompares++;
      $display("FAIL collide_old: got taken=%b target=%h, want 0/00000204", pred_taken, pred_target);
    end
    @(posedge clk); #1;
    upd_valid = 1'b0;
    vectors++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h300) begin
      miscompares++;
      $display("FAIL collide_mp: got mp=%b redirect=%h, want 1/00000300", mispredict, redirect_pc);
    end
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin
      miscompares++;
      $display("FAIL collide_new: got taken=%b target=%h, want 1/00000300", pred_taken, pred_target);
    end
    f_pc = 32'h100; #1;
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      miscompares++;
      $display("FAIL alias_evict: got taken=%b target=%h, want 0/00000104", pred_taken, pred_target);
    end
  endtask

  task automatic test_jalr;
    do_upd(32'h104, 1'b1, 1'b0, 32'h2000, 32'h108);
    vectors++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h2000) begin
      miscompares++;
      $display("FAIL jalr_mp: got mp=%b redirect=%h, want 1/00002000", mispredict, redirect_pc);
    end
    f_pc = 32'h104; #1;
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h2000) begin
      miscompares++;
      $display("FAIL jalr_lookup: got taken=%b target=%h, want 1/00002000", pred_taken, pred_target);
    end
    do_upd(32'h104, 1'b0, 1'b0, 32'h5555, 32'h2000);    // 11 -> 10, still taken
    vectors++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h108) begin
      miscompares++;
      $display("FAIL jalr_nt_mp: got mp=%b redirect=%h, want 1/00000108", mispredict, redirect_pc);
    end
    f_pc = 32'h104; #1;
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h2000) begin
      miscompares++;
      $display("FAIL jalr_sat11: got taken=%b target=%h, want 1/00002000", pred_taken, pred_target);
    end
  endtask

  task automatic test_wrap;
    f_pc = 32'hFFFF_FFFC; #1;
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
      miscompares++;
      $display("FAIL pc_wrap: got taken=%b target=%h, want 0/00000000", pred_taken, pred_target);
    end
  endtask

  task automatic test_back_to_back;
    do_upd(32'h108, 1'b0, 1'b1, 32'h400, 32'h10c);      // 01 -> 10
    vectors++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h400) begin
      miscompares++;
      $display("FAIL b2b_1: got mp=%b redirect=%h, want 1/00000400", mispredict, redirect_pc);
    end
    do_upd(32'h108, 1'b0, 1'b1, 32'h400, 32'h400);      // 10 -> 11
    vectors++;
    if (mispredict !== 1'b0 || redirect_pc !== 32'h400) begin
      miscompares++;
      $display("FAIL b2b_2: got mp=%b redirect=%h, want 0/00000400", mispredict, redirect_pc);
    end
    do_upd(32'h108, 1'b0, 1'b0, 32'h400, 32'h400);      // 11 -> 10
    vectors++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h10c) begin
      miscompares++;
      $display("FAIL b2b_3: got mp=%b redirect=%h, want 1/0000010c", mispredict, redirect_pc);
    end
    f_pc = 32'h108; #1;
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h400) begin
      miscompares++;
      $display("FAIL b2b_lookup: got taken=%b target=%h, want 1/00000400", pred_taken, pred_target);
    end
  endtask

`ifdef BPRED_STATS_EN
  task automatic test_stats;
    @(negedge clk); rst_n = 1'b0; #1;
    vectors++;
    if (stat_updates !== 32'd0 || stat_mispredicts !== 32'd0) begin
      miscompares++;
      $display("FAIL stats_reset: got upd=%0d mp=%0d, want 0/0", stat_updates, stat_mispredicts);
    end
    @(negedge clk); rst_n = 1'b1;
    do_upd(32'h100, 1'b0, 1'b1, 32'h80, 32'h104);       // mispredict
    do_upd(32'h100, 1'b0, 1'b1, 32'h80, 32'h80);        // correct
    do_upd(32'h104, 1'b1, 1'b0, 32'h900, 32'h108);      // mispredict
    @(posedge clk); #1;
    vectors++;
    if (stat_updates !== 32'd3 || stat_mispredicts !== 32'd2) begin
      miscompares++;
      $display("FAIL stats_count: got upd=%0d mp=%0d, want 3/2", stat_updates, stat_mispredicts);
    end
  endtask
`endif

  task automatic test_mid_reset;
    do_upd(32'h100, 1'b0, 1'b1, 32'h80, 32'h104);
    vectors++;
    if (mispredict !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_pre: got mp=%b, want 1", mispredict);
    end
    rst_n = 1'b0; f_pc = 32'h100; #1;
    vectors++;
    if (mispredict !== 1'b0 || redirect_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL midrst_regs: got mp=%b redirect=%h, want 0/00000000", mispredict, redirect_pc);
    end
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      miscompares++;
      $display("FAIL midrst_lookup: got taken=%b target=%h, want 0/00000104", pred_taken, pred_target);
    end
`ifdef BPRED_STATS_EN
    vectors++;
    if (stat_updates !== 32'd0 || stat_mispredicts !== 32'd0) begin
      miscompares++;
      $display("FAIL midrst_stats: got upd=%0d mp=%0d, want 0/0", stat_updates, stat_mispredicts);
    end
`endif
    @(negedge clk); rst_n = 1'b1;
    f_pc = 32'h108; #1;
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h10c) begin
      miscompares++;
      $display("FAIL midrst_clear: got taken=%b target=%h, want 0/0000010c", pred_taken, pred_target);
    end
  endtask

  initial begin
    test_reset();
    test_cold_taken();
    test_saturation();
    test_correct();
    test_alias();
    test_jalr();
    test_wrap();
    test_back_to_back();
`ifdef BPRED_STATS_EN
    test_stats();
`endif
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
